mmio_port_responder: RTL and testbench

- Memory-mapped I/O responder for the pipelined MIPS core's MEM-stage data bus: it is the target end of the Address/WriteData/MemWrite/MemRead/ReadData interface that the core drives as initiator.
- Decodes a 32-byte window at BASE_ADDR and provides these registers:
  - the output port register;
  - a synchronized input port with change detection;
  - a free-running timer with compare;
  - a byte TX FIFO drained by an external valid/ready consumer.
- The top level muxes ReadData between DataMemory and this block using `sel`.

---
 rtl/mmio_pkg.sv | 30 +++
 rtl/mmio_tx_fifo.sv | 58 +++++
 rtl/mmio_port_responder.sv | 140 ++++++++++++++
 tb/tb_mmio_port_responder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO port responder: register offsets, STATUS bit
// positions and the default window base.
package mmio_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hFFFF_0000;

  // Word offsets (Address[4:2]) inside the 32-byte window
  localparam logic [2:0] OFF_PORT_OUT  = 3'd0;
  localparam logic [2:0] OFF_PORT_IN   = 3'd1;
  localparam logic [2:0] OFF_STATUS    = 3'd2;
  localparam logic [2:0] OFF_TX_FIFO   = 3'd3;
  localparam logic [2:0] OFF_TIMER     = 3'd4;
  localparam logic [2:0] OFF_TIMER_CMP = 3'd5;

  // STATUS bit positions
  localparam int ST_IN_CHANGED = 0;
  localparam int ST_FIFO_FULL  = 1;
  localparam int ST_FIFO_EMPTY = 2;
  localparam int ST_TIMER_HIT  = 3;
  localparam int ST_FIFO_OVF   = 4;
  localparam int ST_COUNT_LSB  = 5;

  localparam logic [31:0] TIMER_CMP_RESET = 32'hFFFF_FFFF;

  // STATUS only has three bits for the FIFO fill level; clamp deeper FIFOs
  function automatic logic [2:0] sat_count3(input logic [31:0] c);
    return (c > 32'd7) ? 3'd7 : c[2:0];
  endfunction

endpackage

// File: rtl/mmio_tx_fifo.sv
// Byte TX FIFO with registered-array head. A push while full is dropped unless
// a pop happens in the same cycle; the drop is reported as a one-cycle pulse.
module mmio_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign head     = mem_q[rd_ptr_q];
  assign overflow = push & full & ~pop;

  // Accept/advance decisions; pointers wrap naturally at the power-of-2 depth
  always_comb begin
    pop_ok   = pop & ~empty;
    push_ok  = push & (~full | pop_ok);
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  // Storage and pointer state; storage cleared so head reads 0 out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mmio_port_responder.sv
// MMIO target on the MEM-stage data bus: output port, synchronized input port
// with change detect, free-running timer with compare, and a byte TX FIFO.
module mmio_port_responder
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = DEFAULT_BASE_ADDR,
  parameter int          FIFO_DEPTH    = 4,
  parameter int          PORT_IN_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              Address,
  input  logic [31:0]              WriteData,
  input  logic                     MemWrite,
  input  logic                     MemRead,
  output logic [31:0]              ReadData,
  output logic                     sel,
  input  logic [PORT_IN_WIDTH-1:0] PortIn,
  output logic [31:0]              PortOut,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [2:0]               offset;
  logic                     wr_en, rd_en;
  logic [31:0]              port_out_q, port_out_d;
  logic [31:0]              timer_q, timer_d;
  logic [31:0]              timer_cmp_q, timer_cmp_d;
  logic [PORT_IN_WIDTH-1:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic                     in_changed_q, in_changed_d;
  logic                     timer_hit_q, timer_hit_d;
  logic                     fifo_ovf_q, fifo_ovf_d;
  logic                     status_clr;
  logic [7:0]               status;
  logic                     fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_ovf_pulse;
  logic [CW-1:0]            fifo_count;
  logic                     unused_addr_lsbs;

  assign unused_addr_lsbs = ^Address[1:0];

  assign sel    = (Address[31:5] == BASE_ADDR[31:5]);
  assign offset = Address[4:2];
  assign wr_en  = MemWrite & sel;
  assign rd_en  = MemRead & sel;

  assign fifo_push = wr_en & (offset == OFF_TX_FIFO);
  assign fifo_pop  = tx_valid & tx_ready;

  mmio_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk       (clk),
    .rst       (reset),
    .push      (fifo_push),
    .push_data (WriteData[7:0]),
    .pop       (fifo_pop),
    .head      (tx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .overflow  (fifo_ovf_pulse)
  );

  assign tx_valid = ~fifo_empty;
  assign PortOut  = port_out_q;
  assign irq      = in_changed_q | timer_hit_q;

  // STATUS image assembled from live FIFO flags and sticky bits
  always_comb begin
    status                = '0;
    status[ST_IN_CHANGED] = in_changed_q;
    status[ST_FIFO_FULL]  = fifo_full;
    status[ST_FIFO_EMPTY] = fifo_empty;
    status[ST_TIMER_HIT]  = timer_hit_q;
    status[ST_FIFO_OVF]   = fifo_ovf_q;
    status[7:ST_COUNT_LSB] = sat_count3(32'(fifo_count));
  end

  // Read mux: pure function of current state and Address (pre-write view)
  always_comb begin
    ReadData = '0;
    if (sel) begin
      case (offset)
        OFF_PORT_OUT:  ReadData = port_out_q;
        OFF_PORT_IN:   ReadData = 32'(sync2_q);
        OFF_STATUS:    ReadData = {24'd0, status};
        OFF_TIMER:     ReadData = timer_q;
        OFF_TIMER_CMP: ReadData = timer_cmp_q;
        default:       ReadData = '0;
      endcase
    end
  end

  // Next-state: register writes, timer, synchronizer and sticky set/clear
  always_comb begin
    status_clr  = rd_en & (offset == OFF_STATUS);
    port_out_d  = (wr_en && offset == OFF_PORT_OUT)  ? WriteData : port_out_q;
    timer_cmp_d = (wr_en && offset == OFF_TIMER_CMP) ? WriteData : timer_cmp_q;
    // a load beats the increment
    timer_d     = (wr_en && offset == OFF_TIMER)     ? WriteData : timer_q + 32'd1;
    sync1_d     = PortIn;
    sync2_d     = sync1_q;
    prev_d      = sync2_q;
    // set wins over a same-cycle read clear
    in_changed_d = (sync2_q != prev_q)       | (in_changed_q & ~status_clr);
    timer_hit_d  = (timer_q == timer_cmp_q)  | (timer_hit_q  & ~status_clr);
    fifo_ovf_d   = fifo_ovf_pulse            | (fifo_ovf_q   & ~status_clr);
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      port_out_q   <= '0;
      timer_q      <= '0;
      timer_cmp_q  <= TIMER_CMP_RESET;
      sync1_q      <= '0;
      sync2_q      <= '0;
      prev_q       <= '0;
      in_changed_q <= 1'b0;
      timer_hit_q  <= 1'b0;
      fifo_ovf_q   <= 1'b0;
    end else begin
      port_out_q   <= port_out_d;
      timer_q      <= timer_d;
      timer_cmp_q  <= timer_cmp_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      prev_q       <= prev_d;
      in_changed_q <= in_changed_d;
      timer_hit_q  <= timer_hit_d;
      fifo_ovf_q   <= fifo_ovf_d;
    end
  end

endmodule

// File: tb/tb_mmio_port_responder.sv
// Bench for mmio_port_responder: directed walk through the register map plus
// randomized bus traffic, all checked against a queue-based behavioural model.
module tb_mmio_port_responder;

  localparam int DEPTH = 4;
  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic        clk, reset;
  logic [31:0] Address, WriteData, ReadData, PortOut;
  logic        MemWrite, MemRead, sel, tx_valid, tx_ready, irq;
  logic [7:0]  PortIn, tx_data;

  mmio_port_responder dut (
    .clk       (clk),
    .reset     (reset),
    .Address   (Address),
    .WriteData (WriteData),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .ReadData  (ReadData),
    .sel       (sel),
    .PortIn    (PortIn),
    .PortOut   (PortOut),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_pout, m_timer, m_cmp;
  logic        m_inchg, m_hit, m_ovf;
  logic [7:0]  m_pin_hist [3];   // PortIn as seen 1, 2 and 3 edges ago
  logic [7:0]  m_q [$];          // TX FIFO contents, head at index 0

  function automatic logic in_win(input logic [31:0] a);
    return a[31:5] == BASE[31:5];
  endfunction

  function automatic logic [31:0] m_status();
    int n;
    logic [2:0] c;
    n = m_q.size();
    c = (n > 7) ? 3'd7 : 3'(n);
    return {24'd0, c, m_ovf, m_hit, (n == 0), (n == DEPTH), m_inchg};
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (!in_win(a)) return 32'd0;
    case (a[4:2])
      3'd0:    return m_pout;
      3'd1:    return {24'd0, m_pin_hist[1]};
      3'd2:    return m_status();
      3'd4:    return m_timer;
      3'd5:    return m_cmp;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_reset();
    m_pout = 0; m_timer = 0; m_cmp = 32'hFFFF_FFFF;
    m_inchg = 0; m_hit = 0; m_ovf = 0;
    for (int i = 0; i < 3; i++) m_pin_hist[i] = 8'd0;
    m_q.delete();
  endtask

  // Advance the model by one clock edge using the inputs present before it
  task automatic m_edge(input logic we, input logic re, input logic [31:0] a,
                        input logic [31:0] wd, input logic [7:0] pin, input logic rdy);
    logic w, clr, set_in, set_hit, pop, push, drop;
    logic [2:0] off;
    w       = we && in_win(a);
    off     = a[4:2];
    clr     = re && in_win(a) && off == 3'd2;
    set_in  = m_pin_hist[1] != m_pin_hist[2];
    set_hit = m_timer == m_cmp;
    pop     = rdy && m_q.size() > 0;
    push    = w && off == 3'd3;
    drop    = push && m_q.size() == DEPTH && !pop;
    if (pop) void'(m_q.pop_front());
    if (push && !drop) m_q.push_back(wd[7:0]);
    m_inchg = set_in  ? 1'b1 : (clr ? 1'b0 : m_inchg);
    m_hit   = set_hit ? 1'b1 : (clr ? 1'b0 : m_hit);
    m_ovf   = drop    ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_timer = (w && off == 3'd4) ? wd : m_timer + 32'd1;
    if (w && off == 3'd5) m_cmp  = wd;
    if (w && off == 3'd0) m_pout = wd;
    m_pin_hist[2] = m_pin_hist[1];
    m_pin_hist[1] = m_pin_hist[0];
    m_pin_hist[0] = pin;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".PortOut"}, PortOut, m_pout);
    chk({tag, ".tx_valid"}, {31'd0, tx_valid}, {31'd0, m_q.size() > 0});
    if (m_q.size() > 0) chk({tag, ".tx_data"}, {24'd0, tx_data}, {24'd0, m_q[0]});
    chk({tag, ".irq"}, {31'd0, irq}, {31'd0, m_inchg | m_hit});
  endtask

  // One bus cycle; called at posedge+1 and returns at the next posedge+1
  task automatic step(input logic we, input logic re, input logic [31:0] a, input logic [31:0] wd);
    MemWrite = we; MemRead = re; Address = a; WriteData = wd;
    @(negedge clk);
    #1;
    chk("sel", {31'd0, sel}, {31'd0, in_win(a)});
    chk("rdata", ReadData, m_read(a));
    @(posedge clk);
    m_edge(we, re, a, wd, PortIn, tx_ready);
    #1;
    chk_regs("post");
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  // Asynchronous reset assertion with immediate output check
  task automatic do_reset();
    reset = 1'b1;
    m_reset();
    #1;
    chk("rst.tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst.tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst.irq", {31'd0, irq}, 32'd0);
    chk("rst.PortOut", PortOut, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] a, wd;
    logic [2:0]  off;
    reset = 1'b1; MemWrite = 0; MemRead = 0; Address = 0; WriteData = 0;
    PortIn = 8'h00; tx_ready = 1'b0;
    m_reset();
    #2;
    do_reset();

    // Reset register values
    step(0, 1, BASE + 32'h08, 0);
    chk("rst.status", ReadData, 32'h04);  // still driven after the edge
    step(0, 1, BASE + 32'h14, 0);

    // Output port, then an out-of-window access
    step(1, 0, BASE + 32'h00, 32'hA5A5_0001);
    step(1, 1, 32'h0FFF_0000, 32'h1234_5678);
    step(0, 1, BASE + 32'h02, 0);          // low address bits ignored

    // Input port synchronizer and change detect
    PortIn = 8'h3C;
    idle(); idle();
    step(0, 1, BASE + 32'h04, 0);
    step(0, 1, BASE + 32'h08, 0);
    step(0, 1, BASE + 32'h08, 0);

    // Timer compare and wrap
    step(1, 0, BASE + 32'h14, 32'd13);
    step(1, 0, BASE + 32'h10, 32'd10);
    idle(); idle(); idle(); idle();
    step(0, 1, BASE + 32'h08, 0);
    step(1, 0, BASE + 32'h10, 32'hFFFF_FFFF);
    step(0, 1, BASE + 32'h10, 0);
    step(1, 0, BASE + 32'h14, 32'hFFFF_0000);

    // FIFO fill past full, then drain
    tx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) step(1, 0, BASE + 32'h0C, 32'(i * 8'h11));
    step(0, 1, BASE + 32'h08, 0);
    tx_ready = 1'b1;
    for (int i = 0; i < 5; i++) idle();

    // Full FIFO with push and pop together, then reset mid-drain
    tx_ready = 1'b0;
    for (int i = 1; i <= 4; i++) step(1, 0, BASE + 32'h0C, 32'(i * 8'h11));
    tx_ready = 1'b1;
    step(1, 0, BASE + 32'h0C, 32'h66);
    step(0, 1, BASE + 32'h08, 0);
    idle();
    do_reset();
    step(0, 1, BASE + 32'h08, 0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      off = 3'($urandom_range(0, 7));
      a   = ($urandom_range(0, 7) == 0) ? $urandom() : (BASE | {27'd0, off, 2'($urandom())});
      wd  = $urandom();
      if (off == 3'd5 && $urandom_range(0, 1) == 1) wd = m_timer + 32'($urandom_range(0, 6));
      if (off == 3'd4 && $urandom_range(0, 1) == 1) wd = m_cmp - 32'($urandom_range(0, 6));
      if ($urandom_range(0, 7) == 0) PortIn = 8'($urandom());
      tx_ready = ($urandom_range(0, 2) != 0);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, wd);
      if (n == 300) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
